// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one fpu between N requesters, with an issue-to-result watchdog.
// state | meaning: IDLE no op | ISSUE input_rdy up | WAIT await output_rdy | ACK output_ack up | RESP hold response
module fpu_arbiter #(
    parameter int          N              = 2,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] NAN_VALUE      = 32'hFFFF_FFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    input  logic [4*N-1:0]    req_op,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    output logic [N-1:0]      req_ready,
    output logic [N-1:0]      rsp_valid,
    output logic [31:0]       rsp_result,
    output logic              rsp_error,
    input  logic [N-1:0]      rsp_ack,
    output logic [3:0]        fpu_operation,
    output logic [31:0]       fpu_data_a,
    output logic [31:0]       fpu_data_b,
    output logic              fpu_input_rdy,
    input  logic              fpu_input_ack,
    input  logic              fpu_output_rdy,
    output logic              fpu_output_ack,
    input  logic [31:0]       fpu_result,
    output logic              fpu_flush,
    output logic              busy
);

    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       result_q, result_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_q, flush_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W:0]     cand;
    logic [N-1:0]      grant_pulse;
    logic              abort;
    logic              cnt_at_limit;

    // Scan rr_ptr, rr_ptr+1, ... wrapping at N; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N)) begin
                cand = cand - (ID_W+1)'(N);
            end
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        result_d       = result_q;
        error_d        = error_q;
        cnt_d          = cnt_q;
        flush_d        = 1'b0;
        abort          = 1'b0;
        grant_pulse    = '0;
        rsp_valid      = '0;
        rsp_result     = '0;
        rsp_error      = 1'b0;
        fpu_input_rdy  = 1'b0;
        fpu_output_ack = 1'b0;
        fpu_operation  = '0;
        fpu_data_a     = '0;
        fpu_data_b     = '0;
        cnt_at_limit   = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    grant_pulse[gnt_id] = 1'b1;
                    id_d    = gnt_id;
                    op_d    = req_op[4*gnt_id +: 4];
                    a_d     = req_a[32*gnt_id +: 32];
                    b_d     = req_b[32*gnt_id +: 32];
                    cnt_d   = '0;
                    error_d = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_input_rdy = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (fpu_input_ack) begin
                    state_d = S_WAIT;
                end else if (cnt_at_limit) begin
                    abort = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (fpu_output_rdy) begin
                    result_d = fpu_result;
                    state_d  = S_ACK;
                end else if (cnt_at_limit) begin
                    abort = 1'b1;
                end
            end
            S_ACK: begin
                fpu_output_ack = 1'b1;
                if (!fpu_output_rdy) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[id_q] = 1'b1;
                rsp_result      = result_q;
                rsp_error       = error_q;
                if (rsp_ack[id_q]) begin
                    rr_ptr_d = (id_q == ID_W'(N - 1)) ? '0 : id_q + 1'b1;
                    cnt_d    = '0;
                    error_d  = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A handshake exit in the same cycle has already pre-empted abort above.
        if (abort) begin
            result_d = NAN_VALUE;
            error_d  = 1'b1;
            flush_d  = 1'b1;
            state_d  = S_RESP;
        end

        if (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_ACK) begin
            fpu_operation = op_q;
            fpu_data_a    = a_q;
            fpu_data_b    = b_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
        end
    end

    // Grant is combinational in IDLE, so mask it while reset holds the FSM.
    assign req_ready = reset ? '0 : grant_pulse;
    assign fpu_flush = flush_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: behavioural fpu responder plus a round-robin reference model
// predicting grant order, routed results, timeout timing and reset behaviour.
module tb_fpu_arbiter;
    localparam int          N   = 2;
    localparam int          TO  = 64;
    localparam logic [31:0] NAN = 32'hFFFF_FFFF;

    logic              clock;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [4*N-1:0]    req_op;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_result;
    logic              rsp_error;
    logic [N-1:0]      rsp_ack;
    logic [3:0]        fpu_operation;
    logic [31:0]       fpu_data_a;
    logic [31:0]       fpu_data_b;
    logic              fpu_input_rdy;
    logic              fpu_input_ack;
    logic              fpu_output_rdy;
    logic              fpu_output_ack;
    logic [31:0]       fpu_result;
    logic              fpu_flush;
    logic              busy;

    fpu_arbiter #(.N(N), .TIMEOUT_CYCLES(TO), .NAN_VALUE(NAN)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .rsp_ack(rsp_ack),
        .fpu_operation(fpu_operation), .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b),
        .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
        .fpu_output_rdy(fpu_output_rdy), .fpu_output_ack(fpu_output_ack),
        .fpu_result(fpu_result), .fpu_flush(fpu_flush), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    bit          pend [N];
    logic [3:0]  p_op [N];
    logic [31:0] p_a  [N];
    logic [31:0] p_b  [N];
    int          exp_ptr = 0;

    int          cfg_ack_dly = 1;
    int          cfg_res_dly = 3;
    bit          cfg_hang = 1'b0;
    bit          cfg_force = 1'b0;
    logic [31:0] cfg_force_val = '0;
    logic [3:0]  seen_op = '0;
    logic [31:0] seen_a = '0;
    logic [31:0] seen_b = '0;

    function automatic logic [31:0] fpu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        return (a ^ {b[15:0], b[31:16]}) + {28'd0, op};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Fpu responder: acks issue after cfg_ack_dly, returns result after cfg_res_dly.
    int m_phase = 0;
    int m_cnt = 0;
    initial begin
        fpu_input_ack  = 1'b0;
        fpu_output_rdy = 1'b0;
        fpu_result     = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset || fpu_flush) begin
                fpu_input_ack  = 1'b0;
                fpu_output_rdy = 1'b0;
                m_phase = 0;
                m_cnt   = 0;
            end else begin
                case (m_phase)
                    0: if (fpu_input_rdy) begin
                        m_cnt++;
                        if (m_cnt >= cfg_ack_dly) begin
                            fpu_input_ack = 1'b1;
                            seen_op = fpu_operation;
                            seen_a  = fpu_data_a;
                            seen_b  = fpu_data_b;
                            m_phase = 1;
                        end
                    end
                    1: begin
                        fpu_input_ack = 1'b0;
                        m_cnt   = 0;
                        m_phase = 2;
                    end
                    2: begin
                        m_cnt++;
                        if (!cfg_hang && m_cnt >= cfg_res_dly) begin
                            fpu_output_rdy = 1'b1;
                            fpu_result = cfg_force ? cfg_force_val : fpu_fn(seen_op, seen_a, seen_b);
                            m_phase = 3;
                        end
                    end
                    default: if (fpu_output_ack) begin
                        fpu_output_rdy = 1'b0;
                        fpu_result = $urandom;
                        m_phase = 0;
                        m_cnt   = 0;
                    end
                endcase
            end
        end
    end

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pend[i];
            req_op[4*i +: 4]    = p_op[i];
            req_a[32*i +: 32]   = p_a[i];
            req_b[32*i +: 32]   = p_b[i];
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        pend[i] = 1'b1;
        p_op[i] = op;
        p_a[i]  = a;
        p_b[i]  = b;
    endtask

    task automatic set_rand_req(input int i);
        set_req(i, 4'($urandom), $urandom, $urandom);
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            if (pend[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    task automatic run_txn(input int ack_dly, input int res_dly, input int rsp_dly,
                           input bit hang, input string tag);
        int          id;
        int          cyc;
        bit          stray;
        bit          stable;
        logic [3:0]  e_op;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] exp_res;
        logic [31:0] hold_r;
        logic [N-1:0] other;
        cfg_ack_dly = ack_dly;
        cfg_res_dly = res_dly;
        cfg_hang    = hang;
        id   = exp_grant();
        e_op = p_op[id];
        e_a  = p_a[id];
        e_b  = p_b[id];
        exp_res = hang ? NAN : (cfg_force ? cfg_force_val : fpu_fn(e_op, e_a, e_b));
        drive_reqs();
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_grant"}, 64'(req_ready), 64'(1) << id);
        tick();
        pend[id] = 1'b0;
        p_op[id] = 4'($urandom);
        p_a[id]  = $urandom;
        p_b[id]  = $urandom;
        drive_reqs();
        #1;
        check({tag, "_issue"}, {busy, fpu_input_rdy, fpu_operation, fpu_data_a},
              {1'b1, 1'b1, e_op, e_a});
        check({tag, "_issue_b"}, 64'(fpu_data_b), 64'(e_b));
        cyc = 0;
        stray = 1'b0;
        while (rsp_valid == '0 && cyc < 300) begin
            if (req_ready != '0) stray = 1'b1;
            tick();
            cyc++;
        end
        if (rsp_valid == '0) begin
            check({tag, "_rsp_wait_bound"}, 64'(cyc), 64'(-1));
            return;
        end
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1) << id);
        check({tag, "_rsp_data"}, {rsp_error, rsp_result, fpu_flush}, {hang, exp_res, hang});
        check({tag, "_no_grant_in_flight"}, 64'(stray), 64'(0));
        if (hang) check({tag, "_timeout_cycles"}, 64'(cyc), 64'(TO));
        if (ack_dly < TO) check({tag, "_fpu_operands"}, {seen_op, seen_a, 28'd0},
                                {e_op, e_a, 28'd0});
        if (ack_dly < TO) check({tag, "_fpu_operand_b"}, 64'(seen_b), 64'(e_b));
        hold_r = rsp_result;
        stable = 1'b1;
        for (int k = 0; k < rsp_dly; k++) begin
            other = N'($urandom) & ~(N'(1) << id);
            rsp_ack = other;
            tick();
            if (hang && k == 0) check({tag, "_flush_one_cycle"}, 64'(fpu_flush), 64'(0));
            if (rsp_valid !== (N'(1) << id) || rsp_result !== hold_r || req_ready != '0)
                stable = 1'b0;
        end
        if (rsp_dly > 0) check({tag, "_rsp_hold"}, 64'(stable), 64'(1));
        rsp_ack = N'(1) << id;
        tick();
        rsp_ack = '0;
        #1;
        check({tag, "_release"}, {busy, rsp_valid}, '0);
        exp_ptr = (id + 1) % N;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_pend();
        drive_reqs();
        tick();
        tick();
        reset = 1'b0;
        exp_ptr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit observed=expired required=finish");
        $fatal(1);
    end

    initial begin
        int r;
        reset     = 1'b1;
        req_valid = '1;
        req_op    = '1;
        req_a     = '1;
        req_b     = '1;
        rsp_ack   = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0;
        end
        tick();
        tick();
        check("reset_ctrl", {req_ready, rsp_valid, busy, fpu_input_rdy, fpu_output_ack, fpu_flush},
              '0);
        check("reset_data", {rsp_error, rsp_result, fpu_operation, fpu_data_a}, '0);
        reset = 1'b0;
        drive_reqs();
        tick();

        // single request with a known fpu result
        set_req(0, 4'b0000, 32'h3F80_0000, 32'h4000_0000);
        cfg_force = 1'b1;
        cfg_force_val = 32'h4040_0000;
        run_txn(1, 3, 2, 1'b0, "single");
        cfg_force = 1'b0;

        // simultaneous requests after reset: 0 then 1
        do_reset();
        set_rand_req(0);
        set_rand_req(1);
        run_txn(1, 2, 0, 1'b0, "simul0");
        run_txn(2, 1, 1, 1'b0, "simul1");

        // fairness with both requesters continuously valid
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) set_rand_req(i);
            run_txn(1, 1 + n, 0, 1'b0, "fair");
        end
        clear_pend();

        // watchdog: hang in WAIT, then hang in ISSUE
        set_rand_req(1);
        run_txn(1, 1, 3, 1'b1, "timeout_wait");
        set_rand_req(0);
        run_txn(1000, 1, 1, 1'b1, "timeout_issue");

        // response backpressure with another requester waiting
        set_rand_req(0);
        set_rand_req(1);
        run_txn(2, 2, 10, 1'b0, "backpressure");

        // randomized traffic
        for (int n = 0; n < 24; n++) begin
            bit any;
            bit hang;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) set_rand_req(i);
                any |= pend[i];
            end
            if (!any) set_rand_req($urandom_range(N - 1, 0));
            hang = ($urandom_range(7, 0) == 0);
            r = $urandom_range(4, 0);
            run_txn($urandom_range(3, 1), $urandom_range(6, 1), hang ? r + 1 : r, hang, "rand");
        end

        // reset while WAIT is in progress
        do_reset();
        set_rand_req(1);
        cfg_ack_dly = 1;
        cfg_res_dly = 40;
        cfg_hang    = 1'b0;
        drive_reqs();
        #1;
        check("rstwait_grant", 64'(req_ready), 64'(2));
        tick();
        pend[1] = 1'b0;
        drive_reqs();
        tick();
        tick();
        tick();
        check("rstwait_in_wait", {busy, fpu_input_rdy, fpu_output_ack}, 3'b100);
        set_rand_req(0);
        set_rand_req(1);
        drive_reqs();
        reset = 1'b1;
        #1;
        check("rstwait_ctrl", {req_ready, rsp_valid, busy, fpu_input_rdy, fpu_output_ack, fpu_flush},
              '0);
        check("rstwait_data", {rsp_error, rsp_result, fpu_operation, fpu_data_a}, '0);
        tick();
        tick();
        reset = 1'b0;
        exp_ptr = 0;
        run_txn(1, 2, 1, 1'b0, "after_rst0");
        run_txn(1, 2, 0, 1'b0, "after_rst1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
Shares a single fpu instance between N requesters (e.g. integer core and vector unit) using round-robin arbitration. Sequences one operation at a time through the fpu's two-sided handshake: input_rdy/input_ack on the issue side, output_rdy/output_ack on the result side. Routes the result back to the granted requester. A watchdog converts a hung fpu operation into an error response and a flush pulse.

Parameters:
N, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 64, max cycles from issue to fpu output_rdy before abort
NAN_VALUE, 32'hFFFF_FFFF, result returned on timeout

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  N  requester i has an operation pending
req_op  in  4*N  operation code of requester i, slice [4i+3:4i]
req_a  in  32*N  operand A of requester i
req_b  in  32*N  operand B of requester i
req_ready  out  N  one-cycle pulse: request i accepted and latched
rsp_valid  out  N  result available for requester i
rsp_result  out  32  result shared by all requesters, valid with rsp_valid
rsp_error  out  1  high with rsp_valid when the result is a timeout NaN
rsp_ack  in  N  requester i consumes its response
fpu_operation  out  4  to fpu operation
fpu_data_a  out  32  to fpu data_a
fpu_data_b  out  32  to fpu data_b
fpu_input_rdy  out  1  to fpu input_rdy
fpu_input_ack  in  1  from fpu input_ack
fpu_output_rdy  in  1  from fpu output_rdy
fpu_output_ack  out  1  to fpu output_ack
fpu_result  in  32  from fpu result
fpu_flush  out  1  one-cycle pulse on timeout; clears the fpu
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; rr_ptr=0; latched op/operands/id/result 0; watchdog counter 0. Reset mid-operation abandons the transaction with no response.
- States: IDLE, ISSUE, WAIT, ACK, RESP.
- IDLE: if any req_valid, grant the first valid index scanning rr_ptr, rr_ptr+1, ... mod N. Latch op/a/b/id, pulse req_ready[id] that cycle, go to ISSUE next cycle. No requests: stay.
- ISSUE: fpu_input_rdy=1. fpu_operation/data_a/data_b driven from latches and stable. Counter increments. On fpu_input_ack=1: go to WAIT next cycle, fpu_input_rdy drops.
- WAIT: counter keeps incrementing. On fpu_output_rdy=1: latch fpu_result and go to ACK.
- ACK: fpu_output_ack=1 held until fpu_output_rdy samples 0, then go to RESP.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 while in ISSUE or WAIT, without the ack/rdy exit that cycle, do all of the following:
  - result=NAN_VALUE, error=1
  - pulse fpu_flush for one cycle
  - go to RESP
  - An exit condition in the same cycle as the timeout wins over the timeout.
- RESP: rsp_valid[id]=1, rsp_result/rsp_error stable until rsp_ack[id]=1. Then go to IDLE, set rr_ptr=(id+1) mod N, clear counter and error. rsp_ack on other indices is ignored.
- Only one transaction is in flight. Other requests wait with req_valid held; no new grant is made before returning to IDLE.
- Minimum latency, request to rsp_valid: grant (1) + ISSUE (≥1) + WAIT (≥1) + ACK (≥1) cycles.
- fpu_operation/data outputs are 0 outside ISSUE/WAIT/ACK.

Test Plan:
1. Single request: req_valid[0], op=4'b0000, a=32'h3F800000, b=32'h40000000; fpu model acks after 1 cycle and returns 32'h40400000 after 3 cycles -> req_ready[0] pulse, rsp_valid[0]=1, rsp_result=32'h40400000, rsp_error=0, busy drops after rsp_ack[0].
2. Simultaneous: req_valid=2'b11 after reset -> requester 0 served first, then 1. Requester 1's operands reach fpu_data_a/b unchanged.
3. Fairness: both requesters continuously valid for 4 operations -> grant order 0,1,0,1.
4. Timeout: fpu never asserts output_rdy -> exactly TIMEOUT_CYCLES cycles after entering ISSUE: rsp_error=1, rsp_result=32'hFFFFFFFF, fpu_flush high for exactly 1 cycle.
5. Backpressure: rsp_ack low for 10 cycles -> rsp_valid and rsp_result held stable, no req_ready pulse to a waiting requester.
6. Reset in WAIT -> all outputs 0 in the same cycle. After release, the new request is granted to index 0 and completes normally.
